// File: rtl/mcs4_cycle_if.sv
// Control and timing bundle between the MCS-4 cycle sequencer and the core boards.
// The master side is the sequencer; the slave side is the consumer or a controller.
interface mcs4_cycle_if #(
  parameter int unsigned CNT_W = 16
);
  logic             poc_in;
  logic             run;
  logic             step;
  logic             clk1;
  logic             clk2;
  logic [7:0]       sub;
  logic             sync_n;
  logic             poc;
  logic             halted;
  logic [CNT_W-1:0] icount;

  modport master (
    input  poc_in, run, step,
    output clk1, clk2, sub, sync_n, poc, halted, icount
  );

  modport slave (
    output poc_in, run, step,
    input  clk1, clk2, sub, sync_n, poc, halted, icount
  );
endinterface

// File: rtl/mcs4_cycle_gen.sv
// MCS-4 instruction-cycle sequencer: internal two-phase clocks, subcycle strobes,
// POC synchronisation, run/halt/single-step control and an instruction counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | just out of reset, sequencer not yet started
// ST_RUN  | position counter advancing (unless POC is asserted)
// ST_HALT | parked at the instruction boundary (position 0)
module mcs4_cycle_gen #(
  parameter int unsigned DIV   = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mcs4_cycle_if.master cyc
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

  localparam logic [7:0] QTR_LOAD = 8'(DIV - 1);

  state_t           state, state_nxt;
  logic [7:0]       qtr_tmr;
  logic [4:0]       pos;
  logic [CNT_W-1:0] icount;
  logic             poc_meta, poc_s;
  logic             active, qtr_tc, cyc_end;

  // pos = {subcycle, quarter}; qtr_tmr counts down the sysclks within one quarter
  assign active  = !poc_s && (state == ST_RUN);
  assign qtr_tc  = (qtr_tmr == 8'd0);
  assign cyc_end = qtr_tc && (pos == 5'd31);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_RUN;
      ST_RUN:  if (!poc_s && cyc_end && !cyc.run) state_nxt = ST_HALT;
      ST_HALT: if (poc_s || cyc.run || cyc.step) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      poc_meta <= 1'b0;
      poc_s    <= 1'b0;
      qtr_tmr  <= QTR_LOAD;
      pos      <= 5'd0;
      icount   <= '0;
    end else begin
      poc_meta <= cyc.poc_in;
      poc_s    <= poc_meta;
      if (poc_s) begin
        qtr_tmr <= QTR_LOAD;
        pos     <= 5'd0;
        icount  <= '0;
      end else if (active) begin
        if (qtr_tc) begin
          qtr_tmr <= QTR_LOAD;
          pos     <= pos + 5'd1;
          if (cyc_end) icount <= icount + CNT_W'(1);
        end else begin
          qtr_tmr <= qtr_tmr - 8'd1;
        end
      end
    end
  end

  assign cyc.sub    = 8'd1 << pos[4:2];
  assign cyc.clk1   = active && (pos[1:0] == 2'd0);
  assign cyc.clk2   = active && (pos[1:0] == 2'd2);
  assign cyc.sync_n = !(active && (pos[4:2] == 3'd7));
  assign cyc.poc    = poc_s;
  assign cyc.halted = (state == ST_HALT);
  assign cyc.icount = icount;
endmodule

// File: tb/tb_mcs4_cycle_gen.sv
// Bench for mcs4_cycle_gen: directed vector table, hand-written DIV/width sequences,
// and randomized stimulus compared against a position-counter reference model.
module tb_mcs4_cycle_gen;
  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic rst1_n = 1'b0;
  logic rst3_n = 1'b0;
  logic rstw_n = 1'b0;

  mcs4_cycle_if #(.CNT_W(16)) if1 ();
  mcs4_cycle_if #(.CNT_W(16)) if3 ();
  mcs4_cycle_if #(.CNT_W(2))  ifw ();

  mcs4_cycle_gen #(.DIV(1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst1_n), .cyc(if1));
  mcs4_cycle_gen #(.DIV(3), .CNT_W(16)) dut3 (.clk(clk), .rst_n(rst3_n), .cyc(if3));
  mcs4_cycle_gen #(.DIV(1), .CNT_W(2))  dutw (.clk(clk), .rst_n(rstw_n), .cyc(ifw));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0]  sub;
    logic        clk1, clk2, sync_n, poc, halted;
    logic [15:0] icount;
  } obs_t;

  typedef struct {
    int  t;
    int  ic;
    bit  halted, started, p1, p2;
  } mdl_t;

  typedef struct {
    int   n;
    bit   rst_n, run, step, poc_in;
    obs_t exp;
  } vec_t;

  obs_t d1, d3, dw;
  assign d1 = {if1.sub, if1.clk1, if1.clk2, if1.sync_n, if1.poc, if1.halted, if1.icount};
  assign d3 = {if3.sub, if3.clk1, if3.clk2, if3.sync_n, if3.poc, if3.halted, if3.icount};
  assign dw = {ifw.sub, ifw.clk1, ifw.clk2, ifw.sync_n, ifw.poc, ifw.halted, 14'd0, ifw.icount};

  // Reference: absolute position t in 0..32*div-1, subcycle/quarter by division.
  function automatic mdl_t mdl_step(mdl_t m, bit rst_n, bit poc_in, bit run, bit step,
                                    int div, int cntw);
    mdl_t n = m;
    bit   act;
    if (!rst_n) begin
      n = '{default: 0};
      return n;
    end
    act       = !m.p2 && !m.halted && m.started;
    n.p1      = poc_in;
    n.p2      = m.p1;
    n.started = 1'b1;
    if (m.p2) begin
      n.t = 0; n.ic = 0; n.halted = 1'b0;
    end else if (m.halted) begin
      if (run || step) n.halted = 1'b0;
    end else if (act) begin
      if (m.t == 32 * div - 1) begin
        n.t  = 0;
        n.ic = (m.ic + 1) % (1 << cntw);
        if (!run) n.halted = 1'b1;
      end else begin
        n.t = m.t + 1;
      end
    end
    return n;
  endfunction

  function automatic obs_t mdl_obs(mdl_t m, int div);
    obs_t o;
    bit   act;
    int   q, s;
    act      = !m.p2 && !m.halted && m.started;
    q        = (m.t / div) % 4;
    s        = m.t / (4 * div);
    o.sub    = 8'(1 << s);
    o.clk1   = act && (q == 0);
    o.clk2   = act && (q == 2);
    o.sync_n = !(act && (s == 7));
    o.poc    = m.p2;
    o.halted = m.halted;
    o.icount = 16'(m.ic);
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (packed sub,clk1,clk2,sync_n,poc,halted,icount)",
               name, got, exp);
    end
  endtask

  mdl_t m1 = '{default: 0};
  mdl_t m3 = '{default: 0};
  mdl_t mw = '{default: 0};

  always @(posedge clk) begin
    m1 = mdl_step(m1, rst1_n, if1.poc_in, if1.run, if1.step, 1, 16);
    m3 = mdl_step(m3, rst3_n, if3.poc_in, if3.run, if3.step, 3, 16);
    mw = mdl_step(mw, rstw_n, ifw.poc_in, ifw.run, ifw.step, 1, 2);
  end

  always @(negedge clk) begin
    check("model_div1", 32'(d1), 32'(mdl_obs(m1, 1)));
    check("model_div3", 32'(d3), 32'(mdl_obs(m3, 3)));
    check("model_cntw2", 32'(dw), 32'(mdl_obs(mw, 1)));
  end

  function automatic vec_t mk(int n, bit r, bit ru, bit st, bit pi, logic [7:0] sb,
                              bit c1, bit c2, bit sn, bit po, bit h, int ic);
    vec_t v;
    v.n = n; v.rst_n = r; v.run = ru; v.step = st; v.poc_in = pi;
    v.exp = {sb, c1, c2, sn, po, h, 16'(ic)};
    return v;
  endfunction

  // {rst_n, run, step, poc_in}; run toggles slowly so halts and resumes both occur
  function automatic logic [3:0] rnd_in(logic [3:0] prev);
    logic r, ru, st, pi;
    r  = ($urandom_range(0, 399) != 0);
    ru = ($urandom_range(0, 39) == 0) ? !prev[2] : prev[2];
    st = ($urandom_range(0, 11) == 0);
    pi = ($urandom_range(0, 149) == 0) ? 1'b1 : (prev[0] && ($urandom_range(0, 5) != 0));
    return {r, ru, st, pi};
  endfunction

  task automatic seq_div1;
    vec_t tbl[$];
    // n  rst run stp poc | sub  c1 c2 sn poc h icount
    tbl.push_back(mk( 2, 0, 1, 0, 0, 8'h01, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk( 1, 1, 1, 0, 0, 8'h01, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk( 2, 1, 1, 0, 0, 8'h01, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk( 2, 1, 1, 0, 0, 8'h02, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(24, 1, 1, 0, 0, 8'h80, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 4, 1, 1, 0, 0, 8'h01, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(64, 1, 1, 0, 0, 8'h01, 1, 0, 1, 0, 0, 3));
    tbl.push_back(mk(12, 1, 1, 0, 0, 8'h08, 1, 0, 1, 0, 0, 3));
    tbl.push_back(mk( 1, 1, 0, 0, 0, 8'h08, 0, 0, 1, 0, 0, 3));
    tbl.push_back(mk(18, 1, 0, 0, 0, 8'h80, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk( 1, 1, 0, 0, 0, 8'h01, 0, 0, 1, 0, 1, 4));
    tbl.push_back(mk( 5, 1, 0, 0, 0, 8'h01, 0, 0, 1, 0, 1, 4));
    tbl.push_back(mk( 1, 1, 0, 1, 0, 8'h01, 1, 0, 1, 0, 0, 4));
    tbl.push_back(mk(10, 1, 0, 0, 0, 8'h04, 0, 1, 1, 0, 0, 4));
    tbl.push_back(mk( 1, 1, 0, 1, 0, 8'h04, 0, 0, 1, 0, 0, 4));
    tbl.push_back(mk(20, 1, 0, 0, 0, 8'h80, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk( 1, 1, 0, 0, 0, 8'h01, 0, 0, 1, 0, 1, 5));
    tbl.push_back(mk( 1, 1, 1, 0, 0, 8'h01, 1, 0, 1, 0, 0, 5));
    tbl.push_back(mk(20, 1, 1, 0, 0, 8'h20, 1, 0, 1, 0, 0, 5));
    tbl.push_back(mk( 1, 1, 1, 0, 1, 8'h20, 0, 0, 1, 0, 0, 5));
    tbl.push_back(mk( 1, 1, 1, 0, 1, 8'h20, 0, 0, 1, 1, 0, 5));
    tbl.push_back(mk( 1, 1, 1, 0, 1, 8'h01, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk( 7, 1, 1, 0, 1, 8'h01, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk( 1, 1, 1, 0, 0, 8'h01, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk( 1, 1, 1, 0, 0, 8'h01, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(32, 1, 1, 0, 0, 8'h01, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(28, 1, 0, 0, 0, 8'h80, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk( 1, 0, 0, 0, 0, 8'h01, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk( 1, 1, 0, 0, 0, 8'h01, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(31, 1, 0, 0, 0, 8'h80, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 1, 1, 0, 0, 0, 8'h01, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk( 1, 1, 1, 1, 0, 8'h01, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk( 2, 1, 1, 0, 0, 8'h01, 0, 1, 1, 0, 0, 1));
    foreach (tbl[i]) begin
      rst1_n     = tbl[i].rst_n;
      if1.run    = tbl[i].run;
      if1.step   = tbl[i].step;
      if1.poc_in = tbl[i].poc_in;
      repeat (tbl[i].n) @(negedge clk);
      check($sformatf("vec%0d", i), 32'(d1), 32'(tbl[i].exp));
    end
    for (int k = 0; k < 3000; k++) begin
      {rst1_n, if1.run, if1.step, if1.poc_in} = rnd_in({rst1_n, if1.run, if1.step, if1.poc_in});
      @(negedge clk);
    end
  endtask

  task automatic seq_div3;
    int low_cnt;
    rst3_n = 1'b0; if3.run = 1'b1; if3.step = 1'b0; if3.poc_in = 1'b0;
    repeat (2) @(negedge clk);
    rst3_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("div3_clk_c%0d", k), {30'd0, if3.clk1, if3.clk2},
            {30'd0, 1'(k <= 3), 1'(k >= 7)});
    end
    low_cnt = 0;
    for (int k = 0; k < 96; k++) begin
      @(negedge clk);
      if (!if3.sync_n) low_cnt++;
    end
    check("div3_sync_low", 32'(low_cnt), 32'd12);
    check("div3_icount", 32'(if3.icount), 32'd1);
    for (int k = 0; k < 3000; k++) begin
      {rst3_n, if3.run, if3.step, if3.poc_in} = rnd_in({rst3_n, if3.run, if3.step, if3.poc_in});
      @(negedge clk);
    end
  endtask

  task automatic seq_cntw;
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rstw_n = 1'b0; ifw.run = 1'b1; ifw.step = 1'b0; ifw.poc_in = 1'b0;
    repeat (2) @(negedge clk);
    rstw_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      repeat (32) @(negedge clk);
      check($sformatf("wrap_icount%0d", k), 32'(ifw.icount), 32'(exp_seq[k]));
    end
    for (int k = 0; k < 3000; k++) begin
      {rstw_n, ifw.run, ifw.step, ifw.poc_in} = rnd_in({rstw_n, ifw.run, ifw.step, ifw.poc_in});
      @(negedge clk);
    end
  endtask

  initial begin
    fork
      seq_div1();
      seq_div3();
      seq_cntw();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
